// File: rtl/dct_pkg.sv
// +--------------------------------------------------------------------------+
// | dct_pkg : shared constants and types for the DCT row front end           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package dct_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int ROW_LEN       = 8;
  localparam int PAIRS         = 4;

  typedef logic signed [DEFAULT_WIDTH:0] pair_t;
endpackage

`default_nettype wire

// File: rtl/dct_row_bank.sv
// +--------------------------------------------------------------------------+
// | dct_row_bank : 8-entry pixel store with butterfly pair add/sub by index  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module dct_row_bank
  import dct_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    i_wr_en,
  input  logic [2:0]              i_wr_idx,
  input  logic [WIDTH-1:0]        i_wr_data,
  input  logic [1:0]              i_sel,
  output logic signed [WIDTH:0]   o_add,
  output logic signed [WIDTH:0]   o_sub
);

  logic [WIDTH-1:0]        r_mem [ROW_LEN];
  logic [2:0]              w_lo_idx;
  logic [2:0]              w_hi_idx;
  logic signed [WIDTH:0]   w_lo_ext;
  logic signed [WIDTH:0]   w_hi_ext;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < ROW_LEN; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  // Pair s combines x[s] with its mirror x[7-s]; sign-extend so the sum never overflows.
  assign w_lo_idx = {1'b0, i_sel};
  assign w_hi_idx = 3'(ROW_LEN - 1) - w_lo_idx;
  assign w_lo_ext = {r_mem[w_lo_idx][WIDTH-1], r_mem[w_lo_idx]};
  assign w_hi_ext = {r_mem[w_hi_idx][WIDTH-1], r_mem[w_hi_idx]};
  assign o_add    = w_lo_ext + w_hi_ext;
  assign o_sub    = w_lo_ext - w_hi_ext;

endmodule

`default_nettype wire

// File: rtl/dct_butterfly_feeder.sv
// +--------------------------------------------------------------------------+
// | dct_butterfly_feeder : ping-pong row buffer emitting 4 butterfly pairs   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module dct_butterfly_feeder
  import dct_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic [WIDTH-1:0]        In_Data,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic signed [WIDTH:0]   Out_Add_Data,
  output logic signed [WIDTH:0]   Out_Sub_Data,
  output logic [1:0]              Out_Sele,
  output logic                    Out_Last
);

  logic [1:0]              r_full;
  logic                    r_wr_bank;
  logic                    r_rd_bank;
  logic [2:0]              r_wr_idx;
  logic [1:0]              r_rd_idx;

  logic                    w_accept;
  logic                    w_xfer;
  logic                    w_wr_done;
  logic                    w_rd_done;
  logic [1:0]              w_set;
  logic [1:0]              w_clr;
  logic signed [WIDTH:0]   w_add [2];
  logic signed [WIDTH:0]   w_sub [2];

  assign In_Ready  = !r_full[r_wr_bank];
  assign Out_Valid = r_full[r_rd_bank];
  assign Out_Sele  = r_rd_idx;
  assign Out_Last  = Out_Valid && (r_rd_idx == 2'(PAIRS - 1));

  assign w_accept  = In_Valid && In_Ready;
  assign w_xfer    = Out_Valid && Out_Ready;
  assign w_wr_done = w_accept && (r_wr_idx == 3'(ROW_LEN - 1));
  assign w_rd_done = w_xfer && (r_rd_idx == 2'(PAIRS - 1));

  // Set and clear always target different banks: a full bank is never written.
  assign w_set = w_wr_done ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr = w_rd_done ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      dct_row_bank #(
        .WIDTH (WIDTH)
      ) u_bank (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .i_wr_en   (w_accept && (r_wr_bank == 1'(b))),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (In_Data),
        .i_sel     (r_rd_idx),
        .o_add     (w_add[b]),
        .o_sub     (w_sub[b])
      );
    end
  endgenerate

  assign Out_Add_Data = w_add[r_rd_bank];
  assign Out_Sub_Data = w_sub[r_rd_bank];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= 3'd0;
      r_rd_idx  <= 2'd0;
    end else begin
      r_full <= (r_full & ~w_clr) | w_set;
      if (w_accept) begin
        r_wr_idx <= r_wr_idx + 3'd1;
        if (w_wr_done) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
      if (w_xfer) begin
        r_rd_idx <= r_rd_idx + 2'd1;
        if (w_rd_done) begin
          r_rd_bank <= ~r_rd_bank;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dct_butterfly_feeder.sv
// +--------------------------------------------------------------------------+
// | tb_dct_butterfly_feeder : table vectors plus scoreboard for the feeder   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dct_butterfly_feeder;

  typedef struct packed {
    logic [7:0][7:0] px;
    logic [3:0][8:0] add;
    logic [3:0][8:0] sub;
  } row_vec_t;

  typedef struct packed {
    logic [8:0] add;
    logic [8:0] sub;
    logic [1:0] sele;
    logic       last;
  } beat_t;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              In_Valid = 1'b0;
  logic              In_Ready;
  logic [7:0]        In_Data = 8'd0;
  logic              Out_Valid;
  logic              Out_Ready = 1'b0;
  logic signed [8:0] Out_Add_Data;
  logic signed [8:0] Out_Sub_Data;
  logic [1:0]        Out_Sele;
  logic              Out_Last;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    stalls   = 0;
  beat_t q[$];

  always #5 Clk = ~Clk;

  dct_butterfly_feeder #(.WIDTH(8)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .In_Valid     (In_Valid),
    .In_Ready     (In_Ready),
    .In_Data      (In_Data),
    .Out_Valid    (Out_Valid),
    .Out_Ready    (Out_Ready),
    .Out_Add_Data (Out_Add_Data),
    .Out_Sub_Data (Out_Sub_Data),
    .Out_Sele     (Out_Sele),
    .Out_Last     (Out_Last)
  );

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Scoreboard: every transfer seen on the output side is matched against the queue.
  always @(negedge Clk) begin
    if (Rst_n && Out_Valid && Out_Ready) begin
      if (q.size() == 0) begin
        fail("unexpected_beat");
      end else begin
        beat_t e;
        e = q.pop_front();
        chk("beat_add", Out_Add_Data, e.add);
        chk("beat_sub", Out_Sub_Data, e.sub);
        chk("beat_sele", {7'd0, Out_Sele}, {7'd0, e.sele});
        chk("beat_last", {8'd0, Out_Last}, {8'd0, e.last});
      end
    end
  end

  function automatic logic [3:0][8:0] model_add(input logic [7:0][7:0] px);
    logic [3:0][8:0] r;
    for (int s = 0; s < 4; s++) r[s] = {px[s][7], px[s]} + {px[7-s][7], px[7-s]};
    return r;
  endfunction

  function automatic logic [3:0][8:0] model_sub(input logic [7:0][7:0] px);
    logic [3:0][8:0] r;
    for (int s = 0; s < 4; s++) r[s] = {px[s][7], px[s]} - {px[7-s][7], px[7-s]};
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepts the pixel.
  task automatic send_pixel(input logic [7:0] d);
    int t;
    In_Valid = 1'b1;
    In_Data  = d;
    t = 0;
    @(negedge Clk);
    if (!In_Ready) stalls++;
    while (!In_Ready && t < 50) begin
      t++;
      @(negedge Clk);
    end
    if (!In_Ready) fail("in_ready_timeout");
    @(posedge Clk);
    #1;
    In_Valid = 1'b0;
  endtask

  task automatic push_row(input logic [3:0][8:0] add, input logic [3:0][8:0] sub);
    for (int s = 0; s < 4; s++) q.push_back({add[s], sub[s], 2'(s), (s == 3)});
  endtask

  task automatic send_row(input logic [7:0][7:0] px, input logic [3:0][8:0] add,
                          input logic [3:0][8:0] sub);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push_row(add, sub);
      send_pixel(px[i]);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 60) begin
      t++;
      @(negedge Clk);
    end
    if (q.size() != 0) begin
      fail("drain_timeout");
      q.delete();
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_reset_state(input string nm);
    @(negedge Clk);
    chk({nm, "_in_ready"}, {8'd0, In_Ready}, 9'd1);
    chk({nm, "_out_valid"}, {8'd0, Out_Valid}, 9'd0);
    chk({nm, "_add"}, Out_Add_Data, 9'd0);
    chk({nm, "_sub"}, Out_Sub_Data, 9'd0);
    chk({nm, "_sele"}, {7'd0, Out_Sele}, 9'd0);
    chk({nm, "_last"}, {8'd0, Out_Last}, 9'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    row_vec_t        vecs [4];
    logic [7:0][7:0] px;
    logic [3:0][8:0] ea, es, ea_a;
    logic [8:0]      hold_add, hold_sub;

    vecs[0].px  = {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    vecs[0].add = {4{9'd90}};
    vecs[0].sub = {-9'sd10, -9'sd30, -9'sd50, -9'sd70};
    vecs[1].px  = {{4{8'h7F}}, {4{8'h80}}};
    vecs[1].add = {4{-9'sd1}};
    vecs[1].sub = {4{-9'sd255}};
    vecs[2].px  = {8{8'h7F}};
    vecs[2].add = {4{9'd254}};
    vecs[2].sub = '0;
    vecs[3].px  = {8{8'h80}};
    vecs[3].add = {4{9'h100}};
    vecs[3].sub = '0;

    repeat (3) @(posedge Clk);
    chk_reset_state("reset");
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    Out_Ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send_row(vecs[v].px, vecs[v].add, vecs[v].sub);
      @(negedge Clk);
      chk("latency_valid", {8'd0, Out_Valid}, 9'd1);
      wait_drain();
    end

    // Backpressure: two rows fill both banks, the 17th pixel must wait.
    Out_Ready = 1'b0;
    for (int i = 0; i < 8; i++) px[i] = 8'(i * 3 + 1);
    ea_a = model_add(px);
    send_row(px, ea_a, model_sub(px));
    for (int i = 0; i < 8; i++) px[i] = 8'(200 + i * 7);
    send_row(px, model_add(px), model_sub(px));
    @(negedge Clk);
    chk("bp_in_ready_low", {8'd0, In_Ready}, 9'd0);
    chk("bp_out_valid", {8'd0, Out_Valid}, 9'd1);
    chk("bp_sele", {7'd0, Out_Sele}, 9'd0);
    chk("bp_add_row1", Out_Add_Data, ea_a[0]);
    hold_add = Out_Add_Data;
    hold_sub = Out_Sub_Data;
    @(posedge Clk);
    #1;
    In_Valid = 1'b1;
    In_Data  = 8'h5A;
    repeat (3) begin
      @(negedge Clk);
      chk("bp_hold_add", Out_Add_Data, hold_add);
      chk("bp_hold_sub", Out_Sub_Data, hold_sub);
      chk("bp_hold_in_ready", {8'd0, In_Ready}, 9'd0);
    end
    @(posedge Clk);
    #1;
    Out_Ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk("bp_release_in_ready", {8'd0, In_Ready}, (k == 4) ? 9'd1 : 9'd0);
    end
    @(posedge Clk);
    #1;
    In_Valid = 1'b0;
    px[0] = 8'h5A;
    for (int i = 1; i < 8; i++) px[i] = 8'(i * 11);
    ea = model_add(px);
    es = model_sub(px);
    for (int i = 1; i < 8; i++) begin
      if (i == 7) push_row(ea, es);
      send_pixel(px[i]);
    end
    wait_drain();

    // Continuous streaming: four rows back to back, no input stall allowed.
    stalls = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) px[i] = 8'($urandom_range(0, 255));
      send_row(px, model_add(px), model_sub(px));
    end
    chk("stream_no_stall", 9'(stalls), 9'd0);
    wait_drain();

    // Reset mid-row discards the partial row.
    for (int i = 0; i < 5; i++) send_pixel(8'hE0 + 8'(i));
    Rst_n = 1'b0;
    chk_reset_state("midreset");
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    px = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    send_row(px, {4{9'd9}}, {-9'sd1, -9'sd3, -9'sd5, -9'sd7});
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
